// File: rtl/acc_pkg.sv
// Shared constants and types for the accumulator datapath and its memory responder.
package acc_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;
endpackage

// File: rtl/acc_mem_array.sv
// DEPTH x DATA_W storage with two write ports (port B has priority) and two registered read ports.
module acc_mem_array
    import acc_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_wa_en,
    input  addr_t i_wa_addr,
    input  word_t i_wa_data,
    input  logic  i_wb_en,
    input  addr_t i_wb_addr,
    input  word_t i_wb_data,
    input  logic  i_ra_en,
    input  addr_t i_ra_addr,
    output word_t o_ra_data,
    input  logic  i_rb_en,
    input  addr_t i_rb_addr,
    output word_t o_rb_data
);
    word_t r_mem [DEPTH];
    word_t r_ra_data;
    word_t r_rb_data;
    logic  w_wa_blocked;

    assign w_wa_blocked = i_wb_en && (i_wb_addr == i_wa_addr);

    // Storage update; a same-address collision keeps the port B word.
    always_ff @(posedge i_clk) begin
        if (i_wb_en) begin
            r_mem[i_wb_addr] <= i_wb_data;
        end
        if (i_wa_en && !w_wa_blocked) begin
            r_mem[i_wa_addr] <= i_wa_data;
        end
    end

    // Registered read ports sample the array before this edge's writes land.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ra_data <= {DATA_W{1'b0}};
            r_rb_data <= {DATA_W{1'b0}};
        end else begin
            if (i_ra_en) begin
                r_ra_data <= r_mem[i_ra_addr];
            end else begin
                r_ra_data <= r_ra_data;
            end
            if (i_rb_en) begin
                r_rb_data <= r_mem[i_rb_addr];
            end else begin
                r_rb_data <= r_rb_data;
            end
        end
    end

    assign o_ra_data = r_ra_data;
    assign o_rb_data = r_rb_data;
endmodule

// File: rtl/acc_memory.sv
// Memory responder for the accumulator initiator: zero-fill sweep after reset,
// one-cycle registered reads, and a host preload/inspect port.
module acc_memory
    import acc_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIN,
    input  logic              ReadEnable,
    input  logic              WriteEnable,
    output logic [DATA_W-1:0] DataOut,
    output logic              ReadValid,
    output logic              InitDone,
    input  logic [ADDR_W-1:0] HostAddress,
    input  logic [DATA_W-1:0] HostData,
    input  logic              HostWrite,
    output logic [DATA_W-1:0] HostReadData
);
    localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

    state_t r_state;
    addr_t  r_cnt;
    logic   r_read_valid;
    logic   r_init_done;

    logic   w_ready;
    logic   w_wa_en;
    addr_t  w_wa_addr;
    word_t  w_wa_data;
    logic   w_wb_en;
    logic   w_ra_en;
    logic   w_rb_en;

    assign w_ready = (r_state == READY) && Reset;

    // Port A carries the zero-fill sweep during INIT and the initiator afterwards.
    always_comb begin
        w_wa_en   = 1'b0;
        w_wa_addr = Address;
        w_wa_data = DataIN;
        w_wb_en   = 1'b0;
        w_ra_en   = 1'b0;
        w_rb_en   = 1'b0;
        if (r_state == INIT) begin
            w_wa_en   = Reset;
            w_wa_addr = r_cnt;
            w_wa_data = {DATA_W{1'b0}};
        end else begin
            w_wa_en = w_ready && WriteEnable;
            w_wb_en = w_ready && HostWrite;
            w_ra_en = w_ready && ReadEnable;
            w_rb_en = w_ready;
        end
    end

    // Sweep FSM plus the ReadValid and InitDone flags.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state      <= INIT;
            r_cnt        <= {ADDR_W{1'b0}};
            r_read_valid <= 1'b0;
            r_init_done  <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + addr_t'(1);
                    if (r_cnt == LAST_ADDR) begin
                        r_state     <= READY;
                        r_init_done <= 1'b1;
                    end
                end
                READY: begin
                    r_state <= READY;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
            r_read_valid <= (r_state == READY) && ReadEnable;
        end
    end

    acc_mem_array u_array (
        .i_clk     (Clock),
        .i_rst_n   (Reset),
        .i_wa_en   (w_wa_en),
        .i_wa_addr (w_wa_addr),
        .i_wa_data (w_wa_data),
        .i_wb_en   (w_wb_en),
        .i_wb_addr (HostAddress),
        .i_wb_data (HostData),
        .i_ra_en   (w_ra_en),
        .i_ra_addr (Address),
        .o_ra_data (DataOut),
        .i_rb_en   (w_rb_en),
        .i_rb_addr (HostAddress),
        .o_rb_data (HostReadData)
    );

    assign ReadValid = r_read_valid;
    assign InitDone  = r_init_done;
endmodule

// File: tb/tb_acc_memory.sv
// Directed self-checking bench for acc_memory with hand-computed expectations.
module tb_acc_memory;
    import acc_pkg::*;

    logic              Clock;
    logic              Reset;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] DataIN;
    logic              ReadEnable;
    logic              WriteEnable;
    logic [DATA_W-1:0] DataOut;
    logic              ReadValid;
    logic              InitDone;
    logic [ADDR_W-1:0] HostAddress;
    logic [DATA_W-1:0] HostData;
    logic              HostWrite;
    logic [DATA_W-1:0] HostReadData;

    int n_checks = 0;
    int n_pass   = 0;

    acc_memory dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Address      (Address),
        .DataIN       (DataIN),
        .ReadEnable   (ReadEnable),
        .WriteEnable  (WriteEnable),
        .DataOut      (DataOut),
        .ReadValid    (ReadValid),
        .InitDone     (InitDone),
        .HostAddress  (HostAddress),
        .HostData     (HostData),
        .HostWrite    (HostWrite),
        .HostReadData (HostReadData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Waits for InitDone, holding init-time requests and checking they are ignored.
    task automatic wait_init(input logic poke);
        int cycles;
        cycles = 0;
        while (InitDone !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
            if (poke && InitDone !== 1'b1) begin
                check("init_rvalid", 32'(ReadValid), 32'd0);
                check("init_dout", 32'(DataOut), 32'd0);
            end
        end
        check("init_cycles", 32'(cycles), 32'd32);
        WriteEnable = 1'b0;
        ReadEnable  = 1'b0;
        HostWrite   = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; Address = 5'd0; DataIN = 16'h0000;
        ReadEnable = 1'b0; WriteEnable = 1'b0;
        HostAddress = 5'd0; HostData = 16'h0000; HostWrite = 1'b0;
        tick();
        tick();
        check("rst_dout", 32'(DataOut), 32'd0);
        check("rst_rvalid", 32'(ReadValid), 32'd0);
        check("rst_done", 32'(InitDone), 32'd0);
        check("rst_hrd", 32'(HostReadData), 32'd0);

        Reset = 1'b1;
        wait_init(1'b0);
        for (int a = 0; a < 32; a++) begin
            HostAddress = 5'(a);
            tick();
            check("zero_fill", 32'(HostReadData), 32'd0);
        end

        // Write then read address 5
        WriteEnable = 1'b1; Address = 5'd5; DataIN = 16'h1234;
        tick();
        WriteEnable = 1'b0; ReadEnable = 1'b1;
        tick();
        check("rd5_data", 32'(DataOut), 32'h1234);
        check("rd5_valid", 32'(ReadValid), 32'd1);
        ReadEnable = 1'b0;
        tick();
        check("idle_valid", 32'(ReadValid), 32'd0);
        check("idle_hold", 32'(DataOut), 32'h1234);

        // Read-before-write on address 3
        HostWrite = 1'b1; HostAddress = 5'd3; HostData = 16'hAAAA;
        tick();
        HostWrite = 1'b0;
        ReadEnable = 1'b1; WriteEnable = 1'b1; Address = 5'd3; DataIN = 16'h5555;
        tick();
        check("rbw_old", 32'(DataOut), 32'hAAAA);
        WriteEnable = 1'b0;
        tick();
        check("rbw_new", 32'(DataOut), 32'h5555);
        ReadEnable = 1'b0;

        // Same-address collision: host wins
        WriteEnable = 1'b1; Address = 5'd7; DataIN = 16'h1111;
        HostWrite = 1'b1; HostAddress = 5'd7; HostData = 16'h2222;
        tick();
        WriteEnable = 1'b0; HostWrite = 1'b0;
        ReadEnable = 1'b1;
        tick();
        check("coll_init", 32'(DataOut), 32'h2222);
        check("coll_host", 32'(HostReadData), 32'h2222);
        ReadEnable = 1'b0;

        // Different addresses: both land
        WriteEnable = 1'b1; Address = 5'd7; DataIN = 16'h1111;
        HostWrite = 1'b1; HostAddress = 5'd8; HostData = 16'h2222;
        tick();
        WriteEnable = 1'b0; HostWrite = 1'b0;
        ReadEnable = 1'b1;
        tick();
        check("dual_7", 32'(DataOut), 32'h1111);
        check("dual_8", 32'(HostReadData), 32'h2222);
        ReadEnable = 1'b0;

        // Host preload then back-to-back burst
        for (int a = 0; a < 32; a++) begin
            HostWrite = 1'b1; HostAddress = 5'(a); HostData = 16'(a + 1);
            tick();
        end
        HostWrite = 1'b0;
        ReadEnable = 1'b1;
        for (int a = 0; a < 32; a++) begin
            Address = 5'(a);
            tick();
            check("burst_valid", 32'(ReadValid), 32'd1);
            check("burst_data", 32'(DataOut), 32'(a + 1));
        end
        ReadEnable = 1'b0;
        tick();
        check("burst_end", 32'(ReadValid), 32'd0);

        // Reset mid-burst
        WriteEnable = 1'b1; Address = 5'd9; DataIN = 16'hBEEF;
        tick();
        WriteEnable = 1'b0; ReadEnable = 1'b1;
        tick();
        check("beef_rd", 32'(DataOut), 32'hBEEF);
        Reset = 1'b0;
        tick();
        check("mid_rst_valid", 32'(ReadValid), 32'd0);
        check("mid_rst_dout", 32'(DataOut), 32'd0);
        check("mid_rst_done", 32'(InitDone), 32'd0);
        Reset = 1'b1;
        WriteEnable = 1'b1; Address = 5'd0; DataIN = 16'h1357;
        HostWrite = 1'b1; HostAddress = 5'd1; HostData = 16'h2468;
        ReadEnable = 1'b1;
        wait_init(1'b1);
        HostAddress = 5'd9;
        tick();
        check("reinit_9", 32'(HostReadData), 32'd0);
        HostAddress = 5'd0;
        tick();
        check("reinit_0", 32'(HostReadData), 32'd0);
        HostAddress = 5'd1;
        tick();
        check("reinit_1", 32'(HostReadData), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
